// File: rtl/load_store_unit_if.sv
// Request and data-memory bus between the core, the load/store unit and dmem.
// The slave modport is the load/store unit's view of the bus.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        err;
   logic        err_sticky;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
      output rdata, stall, err, err_sticky, mem_we, mem_a, mem_wd
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
      input  rdata, stall, err, err_sticky, mem_we, mem_a, mem_wd
   );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit in front of a word-wide data memory.
// Sub-word stores are done as a read-modify-write over two cycles.
module load_store_unit #(
   parameter int MEM_WORDS = 64
) (
   input  logic             clk,
   input  logic             reset,
   load_store_unit_if.slave bus
);
   typedef enum logic {IDLE, RMW_WR} state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   state_t      state_q, state_d;
   logic [31:0] hold_a_q, hold_a_d;
   logic [31:0] hold_wd_q, hold_wd_d;
   logic        err_sticky_q, err_sticky_d;

   logic [31:0] widx;
   logic [1:0]  lane;
   logic        fault;
   logic [31:0] rdata_c, mem_a_c, mem_wd_c;
   logic        stall_c, err_c, mem_we_c;

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] ln, input logic uns);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        res;
      b = word[{ln, 3'b000} +: 8];
      h = ln[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: res = uns ? {24'h0, b} : 32'(b);
         SZ_HALF: res = uns ? {16'h0, h} : 32'(h);
         default: res = word;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] size, input logic [1:0] ln);
      logic [31:0] m;
      m = old;
      if (size == SZ_BYTE) m[{ln, 3'b000} +: 8] = wd[7:0];
      else                 m[{ln[1], 4'b0000} +: 16] = wd[15:0];
      return m;
   endfunction

   assign widx  = {2'b00, bus.req_addr[31:2]};
   assign lane  = bus.req_addr[1:0];
   assign fault = (bus.req_size == 2'b11) ||
                  (bus.req_size == SZ_HALF && lane[0]) ||
                  (bus.req_size == SZ_WORD && lane != 2'b00) ||
                  (widx >= 32'(MEM_WORDS));

   always_comb begin
      rdata_c      = 32'h0;
      stall_c      = 1'b0;
      err_c        = 1'b0;
      mem_we_c     = 1'b0;
      mem_a_c      = widx;
      mem_wd_c     = bus.req_wdata;
      state_d      = state_q;
      hold_a_d     = hold_a_q;
      hold_wd_d    = hold_wd_q;

      if (state_q == RMW_WR) begin
         // Commit the merged word; the request bus is ignored this cycle.
         mem_a_c  = hold_a_q;
         mem_wd_c = hold_wd_q;
         mem_we_c = 1'b1;
         state_d  = IDLE;
      end else if (bus.req_valid) begin
         err_c = fault;
         if (!fault) begin
            if (!bus.req_we) begin
               rdata_c = load_extend(bus.mem_rd, bus.req_size, lane, bus.req_unsigned);
            end else if (bus.req_size == SZ_WORD) begin
               mem_we_c = 1'b1;
            end else begin
               stall_c   = 1'b1;
               hold_a_d  = widx;
               hold_wd_d = store_merge(bus.mem_rd, bus.req_wdata, bus.req_size, lane);
               state_d   = RMW_WR;
            end
         end
      end

      // A write still pending when reset hits is dropped.
      if (reset) mem_we_c = 1'b0;

      err_sticky_d = err_sticky_q | err_c;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         hold_a_q     <= 32'h0;
         hold_wd_q    <= 32'h0;
         err_sticky_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_a_q     <= hold_a_d;
         hold_wd_q    <= hold_wd_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   assign bus.rdata      = rdata_c;
   assign bus.stall      = stall_c;
   assign bus.err        = err_c;
   assign bus.err_sticky = err_sticky_q;
   assign bus.mem_we     = mem_we_c;
   assign bus.mem_a      = mem_a_c;
   assign bus.mem_wd     = mem_wd_c;
endmodule
